// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver/register block and the receive FIFO.
// Handshake: a pop happens on every rising edge where rd_valid_o && rd_ready_i; wr_stb_i is a one-cycle strobe that is never back-pressured.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data_i;
  logic          wr_stb_i;
  logic [7:0]    rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [LW-1:0] level_o;
  logic          full_o;
  logic          empty_o;
  logic          thresh_irq_o;
  logic          overrun_o;
  logic          ovr_clr_i;
  logic [7:0]    drop_cnt_o;
  logic          flush_i;

  modport master (
    output wr_data_i, wr_stb_i, rd_ready_i, ovr_clr_i, flush_i,
    input  rd_data_o, rd_valid_o, level_o, full_o, empty_o,
           thresh_irq_o, overrun_o, drop_cnt_o
  );

  modport slave (
    input  wr_data_i, wr_stb_i, rd_ready_i, ovr_clr_i, flush_i,
    output rd_data_o, rd_valid_o, level_o, full_o, empty_o,
           thresh_irq_o, overrun_o, drop_cnt_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive byte FIFO with level, threshold IRQ, sticky overrun flag
// and a saturating dropped-byte counter.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L = LW'(THRESH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overrun;
  logic [7:0]    drop_cnt;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    full  = (level == DEPTH_L);
    empty = (level == '0);
    pop   = !empty && bus.rd_ready_i;
    push  = bus.wr_stb_i && (!full || pop);
    // A strobe swallowed by a flush is intentionally not a drop.
    drop  = bus.wr_stb_i && full && !pop && !bus.flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; it is only observed through rd_valid_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !bus.flush_i && push) mem[wr_ptr] <= bus.wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (bus.ovr_clr_i)          drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (bus.ovr_clr_i) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_comb begin
    bus.rd_data_o    = mem[rd_ptr];
    bus.rd_valid_o   = !empty;
    bus.level_o      = level;
    bus.full_o       = full;
    bus.empty_o      = empty;
    bus.thresh_irq_o = (level >= THRESH_L);
    bus.overrun_o    = overrun;
    bus.drop_cnt_o   = drop_cnt;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour
// plus hand-written fill/drain, overrun, flush and saturation sequences.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stb;
    logic [7:0] data;
    logic       rdy;
    logic       flush;
    int         exp_level;
    logic       chk_head;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic stb, input logic [7:0] d, input logic rdy,
                       input logic fl, input logic clr);
    bus.wr_stb_i   = stb;
    bus.wr_data_i  = d;
    bus.rd_ready_i = rdy;
    bus.flush_i    = fl;
    bus.ovr_clr_i  = clr;
    @(posedge clk);
    #1;
    bus.wr_stb_i   = 1'b0;
    bus.rd_ready_i = 1'b0;
    bus.flush_i    = 1'b0;
    bus.ovr_clr_i  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int n, input string name);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk({name, "_valid"}, int'(bus.rd_valid_o), 1);
      chk({name, "_data"}, int'(bus.rd_data_o), int'(e));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b1, 8'h3C};
    vecs[4] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1, 1'b1, 8'h7E};
    vecs[5] = '{1'b1, 8'h11, 1'b0, 1'b0, 2, 1'b1, 8'h7E};
    vecs[6] = '{1'b1, 8'h22, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00};

    bus.wr_stb_i = 1'b0; bus.wr_data_i = 8'h00; bus.rd_ready_i = 1'b0;
    bus.flush_i = 1'b0; bus.ovr_clr_i = 1'b0;
    do_reset();

    chk("rst_level", int'(bus.level_o), 0);
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_full", int'(bus.full_o), 0);
    chk("rst_valid", int'(bus.rd_valid_o), 0);
    chk("rst_irq", int'(bus.thresh_irq_o), 0);
    chk("rst_ovr", int'(bus.overrun_o), 0);
    chk("rst_drop", int'(bus.drop_cnt_o), 0);

    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].stb, vecs[i].data, vecs[i].rdy, vecs[i].flush, 1'b0);
      chk($sformatf("vec%0d_level", i), int'(bus.level_o), vecs[i].exp_level);
      chk($sformatf("vec%0d_valid", i), int'(bus.rd_valid_o), int'(vecs[i].exp_level != 0));
      chk($sformatf("vec%0d_empty", i), int'(bus.empty_o), int'(vecs[i].exp_level == 0));
      chk($sformatf("vec%0d_drop", i), int'(bus.drop_cnt_o), 0);
      if (vecs[i].chk_head)
        chk($sformatf("vec%0d_head", i), int'(bus.rd_data_o), int'(vecs[i].exp_head));
    end

    // Fill to full from a fresh reset so pointers wrap on the drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'(i));
      chk($sformatf("fill%0d_level", i), int'(bus.level_o), i + 1);
      chk($sformatf("fill%0d_irq", i), int'(bus.thresh_irq_o), int'(i + 1 >= THRESH));
      chk($sformatf("fill%0d_full", i), int'(bus.full_o), int'(i + 1 == DEPTH));
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovr3_flag", int'(bus.overrun_o), 1);
    chk("ovr3_cnt", int'(bus.drop_cnt_o), 3);
    chk("ovr3_head", int'(bus.rd_data_o), 0);
    chk("ovr3_level", int'(bus.level_o), DEPTH);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_flag", int'(bus.overrun_o), 0);
    chk("clr_cnt", int'(bus.drop_cnt_o), 0);

    // Full with simultaneous push and pop: level holds, no overrun.
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    chk("fullpp_level", int'(bus.level_o), DEPTH);
    chk("fullpp_ovr", int'(bus.overrun_o), 0);
    chk("fullpp_head", int'(bus.rd_data_o), 1);
    drain(DEPTH, "drain");
    chk("drain_empty", int'(bus.empty_o), 1);
    chk("drain_level", int'(bus.level_o), 0);

    // Flush at level 5 with a coincident strobe, while drop_cnt is nonzero.
    for (int i = 0; i < DEPTH; i++) push_byte(8'h40 + 8'(i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    drain(DEPTH - 5, "pre_flush");
    chk("pre_flush_level", int'(bus.level_o), 5);
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
    chk("flush_level", int'(bus.level_o), 0);
    chk("flush_valid", int'(bus.rd_valid_o), 0);
    chk("flush_drop", int'(bus.drop_cnt_o), 2);
    chk("flush_ovr", int'(bus.overrun_o), 1);
    push_byte(8'h66);
    chk("post_flush_head", int'(bus.rd_data_o), 8'h66);
    chk("post_flush_level", int'(bus.level_o), 1);

    // Saturation, then clear coincident with a drop.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("sat_pre_cnt", int'(bus.drop_cnt_o), 0);
    for (int i = 1; i < DEPTH; i++) push_byte(8'(i));
    chk("sat_full", int'(bus.full_o), 1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt", int'(bus.drop_cnt_o), 255);
    chk("sat_head", int'(bus.rd_data_o), 8'h66);
    cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    chk("clrdrop_flag", int'(bus.overrun_o), 1);
    chk("clrdrop_cnt", int'(bus.drop_cnt_o), 1);

    // Reset in the middle of a transfer returns everything to idle.
    rst = 1'b1;
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_level", int'(bus.level_o), 0);
    chk("midrst_valid", int'(bus.rd_valid_o), 0);
    chk("midrst_ovr", int'(bus.overrun_o), 0);
    chk("midrst_drop", int'(bus.drop_cnt_o), 0);
    chk("midrst_irq", int'(bus.thresh_irq_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte that the receiver strobes out and holds the bytes in a show-ahead FIFO. The FIFO is drained by the wishbone register interface through a valid/ready handshake. It also reports fill level, a threshold interrupt, a sticky overrun flag and a saturating count of dropped bytes.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
THRESH, 8, fill level at or above which thresh_irq_o asserts; range 1..DEPTH

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
wr_data_i  in  8  received byte (receiver data_o)
wr_stb_i  in  1  single-cycle byte-valid strobe (receiver ready_o); wr_data_i is valid in the same cycle
rd_data_o  out  8  head-of-FIFO byte, show-ahead
rd_valid_o  out  1  FIFO non-empty; rd_data_o is valid
rd_ready_i  in  1  consumer accepts the head byte
level_o  out  $clog2(DEPTH)+1  current number of stored bytes, 0..DEPTH
full_o  out  1  level_o == DEPTH
empty_o  out  1  level_o == 0
thresh_irq_o  out  1  level_o >= THRESH
overrun_o  out  1  sticky: a byte was dropped because the FIFO was full
ovr_clr_i  in  1  clears overrun_o and drop_cnt_o
drop_cnt_o  out  8  dropped-byte count, saturates at 255
flush_i  in  1  empties the FIFO

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk_i. Only rst_i is synchronous and active-high.
- Reset values:
  - level_o = 0, empty_o = 1, full_o = 0, rd_valid_o = 0.
  - thresh_irq_o = 0, overrun_o = 0, drop_cnt_o = 0.
  - Read and write pointers = 0.
  - Storage array is not reset. rd_data_o is don't-care while rd_valid_o = 0.
- Storage: DEPTH x 8 register array. rd_data_o is read combinationally as mem[rd_ptr].
- Pointers: $clog2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0.
- level: a registered counter. empty_o, full_o, rd_valid_o (= !empty_o) and thresh_irq_o are decoded directly from it, with no extra register stage.
- Pop: occurs when rd_valid_o && rd_ready_i. rd_ptr increments and the next byte appears on rd_data_o in the following cycle.
- Push: occurs when wr_stb_i && (!full_o || pop). mem[wr_ptr] <= wr_data_i and wr_ptr increments.
- Write-to-read latency: a byte strobed in cycle N is visible (rd_valid_o = 1) in cycle N+1. There is no fall-through in the same cycle.
- Level update: push only gives +1, pop only gives -1, push and pop together leave the level unchanged.
- rd_data_o and rd_valid_o hold stable while rd_ready_i = 0.
- Boundary conditions:
  - Empty, with rd_ready_i high: no pop; the level stays at 0.
  - Empty, push and rd_ready_i in the same cycle: push only. The byte is popped no earlier than the next cycle.
  - Full, push with pop in the same cycle: push is accepted, the level stays at DEPTH, and no overrun is flagged.
  - Full, push without pop: the byte is discarded and pointers are unchanged. overrun_o <= 1 and drop_cnt_o increments, saturating at 255.
- ovr_clr_i: clears overrun_o and drop_cnt_o in the next cycle. If a drop occurs in the same cycle, the drop wins: overrun_o = 1 and drop_cnt_o = 1.
- flush_i:
  - Both pointers and the level return to 0 in the next cycle.
  - Any push or pop in the same cycle is ignored, and an ignored push is not counted as a drop.
  - overrun_o and drop_cnt_o are not affected.
- Priority: rst_i > flush_i > push/pop.
- Assertion in rst_i mid-transfer: all state returns to reset values on the next edge. No partial byte is retained.

Test Plan:
- Reset, then strobe 0xA5 in cycle N with rd_ready_i = 0 -> cycle N+1: rd_valid_o = 1, rd_data_o = 0xA5, level_o = 1. Assert rd_ready_i for 1 cycle -> level_o = 0, empty_o = 1.
- DEPTH = 16: write 0x00..0x0F with no reads -> full_o = 1 and thresh_irq_o = 1 from level 8 onward. Read all 16 -> data returns in order 0x00..0x0F, pointers wrap, empty_o = 1.
- Full FIFO, 3 extra strobes with no pop -> overrun_o = 1, drop_cnt_o = 3, head still 0x00. Pulse ovr_clr_i -> overrun_o = 0, drop_cnt_o = 0.
- Full FIFO, wr_stb_i and rd_ready_i asserted together -> level_o stays 16, overrun_o stays 0, and the new byte is read back last.
- Level 5, flush_i together with wr_stb_i -> next cycle level_o = 0, rd_valid_o = 0, drop_cnt_o unchanged.
- 300 strobes into a full FIFO -> drop_cnt_o saturates at 255. ovr_clr_i coincident with a drop -> overrun_o = 1, drop_cnt_o = 1.
